// File: rtl/osc_readout.sv
// Read-side sequencer for the oscillator-count sample memory: sweeps the read port once per
// START and emits a framed byte stream (sync header, samples MSB-first, XOR checksum).
module osc_readout #(
    parameter int unsigned ADD_WIDTH    = 16,
    parameter int unsigned MEM_WIDTH    = 16,
    parameter int unsigned NUM_SAMPLES  = 16384,
    parameter int unsigned READ_LATENCY = 2,
    parameter logic [7:0]  SYNC0        = 8'hA5,
    parameter logic [7:0]  SYNC1        = 8'h5A
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic                 START,
    output logic [ADD_WIDTH-1:0] ADDRESS,
    input  logic [MEM_WIDTH-1:0] MEM_DATA,
    output logic [7:0]           TX_BYTE,
    output logic                 TX_VALID,
    input  logic                 TX_READY,
    output logic                 BUSY,
    output logic                 DONE
);

    localparam int unsigned          NUM_BYTES = MEM_WIDTH / 8;
    localparam int unsigned          IDX_W     = $clog2(NUM_BYTES) + 1;
    localparam logic [ADD_WIDTH-1:0] LAST_ADDR = ADD_WIDTH'(NUM_SAMPLES - 1);
    localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(NUM_BYTES - 1);
    localparam logic [2:0]           LAST_LAT  = 3'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        StIdle,
        StHdr0,
        StHdr1,
        StWait,
        StLoad,
        StSend,
        StCsum,
        StDone
    } state_e;

    state_e               state_q;
    logic [MEM_WIDTH-1:0] shift_q;
    logic [IDX_W-1:0]     byte_idx_q;
    logic [2:0]           lat_cnt_q;
    logic [7:0]           csum_q;

    logic                 xfer;
    logic [MEM_WIDTH-1:0] shift_next;
    logic [7:0]           csum_next;

    assign xfer       = TX_VALID & TX_READY;
    assign shift_next = shift_q << 8;
    assign csum_next  = csum_q ^ TX_BYTE;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q    <= StIdle;
            ADDRESS    <= '0;
            TX_BYTE    <= '0;
            TX_VALID   <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            shift_q    <= '0;
            byte_idx_q <= '0;
            lat_cnt_q  <= '0;
            csum_q     <= '0;
        end else begin
            DONE <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (START) begin
                        state_q  <= StHdr0;
                        BUSY     <= 1'b1;
                        ADDRESS  <= '0;
                        csum_q   <= '0;
                        TX_BYTE  <= SYNC0;
                        TX_VALID <= 1'b1;
                    end
                end
                StHdr0: begin
                    if (xfer) begin
                        TX_BYTE <= SYNC1;
                        state_q <= StHdr1;
                    end
                end
                StHdr1: begin
                    if (xfer) begin
                        TX_VALID  <= 1'b0;
                        lat_cnt_q <= '0;
                        state_q   <= StWait;
                    end
                end
                // ADDRESS is held here, so the memory pipeline settles on the current word
                StWait: begin
                    lat_cnt_q <= lat_cnt_q + 3'd1;
                    if (lat_cnt_q == LAST_LAT) begin
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    shift_q    <= MEM_DATA;
                    TX_BYTE    <= MEM_DATA[MEM_WIDTH-1 -: 8];
                    TX_VALID   <= 1'b1;
                    byte_idx_q <= '0;
                    state_q    <= StSend;
                end
                StSend: begin
                    if (xfer) begin
                        csum_q     <= csum_next;
                        shift_q    <= shift_next;
                        byte_idx_q <= byte_idx_q + 1'b1;
                        if (byte_idx_q == LAST_IDX) begin
                            // Compare before increment so a full address space never wraps
                            if (ADDRESS == LAST_ADDR) begin
                                TX_BYTE <= csum_next;
                                state_q <= StCsum;
                            end else begin
                                ADDRESS   <= ADDRESS + 1'b1;
                                TX_VALID  <= 1'b0;
                                lat_cnt_q <= '0;
                                state_q   <= StWait;
                            end
                        end else begin
                            TX_BYTE <= shift_next[MEM_WIDTH-1 -: 8];
                        end
                    end
                end
                StCsum: begin
                    if (xfer) begin
                        TX_VALID <= 1'b0;
                        DONE     <= 1'b1;
                        state_q  <= StDone;
                    end
                end
                StDone: begin
                    BUSY    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_osc_readout.sv
// Directed bench for osc_readout: frame contents, back-pressure, reset abort, ignored START,
// read-latency variants and a full-address-space sweep.
module tb_osc_readout;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        start_a, start_b, start_c, start_d;
    logic        tx_ready_a;
    logic        ready_one;
    logic [15:0] addr_a, addr_b, addr_c;
    logic [1:0]  addr_d;
    logic [15:0] mem_a, mem_b, mem_c, mem_d;
    logic [7:0]  byte_a, byte_b, byte_c, byte_d;
    logic        valid_a, valid_b, valid_c, valid_d;
    logic        busy_a, busy_b, busy_c, busy_d;
    logic        done_a, done_b, done_c, done_d;

    osc_readout #(.NUM_SAMPLES(3), .READ_LATENCY(2)) u_dut (
        .CLOCK(clock), .RESET(reset), .START(start_a), .ADDRESS(addr_a), .MEM_DATA(mem_a),
        .TX_BYTE(byte_a), .TX_VALID(valid_a), .TX_READY(tx_ready_a), .BUSY(busy_a),
        .DONE(done_a)
    );
    osc_readout #(.NUM_SAMPLES(3), .READ_LATENCY(1)) u_lat1 (
        .CLOCK(clock), .RESET(reset), .START(start_b), .ADDRESS(addr_b), .MEM_DATA(mem_b),
        .TX_BYTE(byte_b), .TX_VALID(valid_b), .TX_READY(ready_one), .BUSY(busy_b),
        .DONE(done_b)
    );
    osc_readout #(.NUM_SAMPLES(3), .READ_LATENCY(3)) u_lat3 (
        .CLOCK(clock), .RESET(reset), .START(start_c), .ADDRESS(addr_c), .MEM_DATA(mem_c),
        .TX_BYTE(byte_c), .TX_VALID(valid_c), .TX_READY(ready_one), .BUSY(busy_c),
        .DONE(done_c)
    );
    osc_readout #(.ADD_WIDTH(2), .NUM_SAMPLES(4), .READ_LATENCY(2)) u_full (
        .CLOCK(clock), .RESET(reset), .START(start_d), .ADDRESS(addr_d), .MEM_DATA(mem_d),
        .TX_BYTE(byte_d), .TX_VALID(valid_d), .TX_READY(ready_one), .BUSY(busy_d),
        .DONE(done_d)
    );

    // Memory models: registered pipelines, depth equal to each instance's read latency
    function automatic logic [15:0] pat(input logic [15:0] a);
        return {a[7:0], ~a[7:0]};
    endfunction

    logic [15:0] pa0, pa1, pb0, pc0, pc1, pc2, pd0, pd1;
    always @(posedge clock) begin
        pa0 <= pat(addr_a);
        pa1 <= pa0;
        pb0 <= pat(addr_b);
        pc0 <= pat(addr_c);
        pc1 <= pc0;
        pc2 <= pc1;
        pd0 <= {4{{2'b00, addr_d}}};
        pd1 <= pd0;
    end
    assign mem_a = pa1;
    assign mem_b = pb0;
    assign mem_c = pc2;
    assign mem_d = pd1;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Transfer monitors
    logic [7:0] q_a[$], q_b[$], q_c[$], q_d[$];
    int         t_a[$], t_b[$], t_c[$], t_d[$];
    int         dn_a = 0, dn_b = 0, dn_c = 0, dn_d = 0;
    int         dc_a = 0;
    int         stall_bad = 0, stall_seen = 0, busy_bad = 0, wrap_d = 0;
    logic       stall_prev = 1'b0, seen3_d = 1'b0;
    logic [7:0] byte_prev = 8'h00;

    always @(posedge clock) begin
        if (valid_a && tx_ready_a && !reset) begin
            q_a.push_back(byte_a);
            t_a.push_back(cyc);
        end
        if (done_a) begin
            dn_a <= dn_a + 1;
            dc_a <= cyc;
        end
        if (stall_prev && (!valid_a || byte_a !== byte_prev)) stall_bad <= stall_bad + 1;
        if (valid_a && !tx_ready_a) stall_seen <= stall_seen + 1;
        if (valid_a && !busy_a) busy_bad <= busy_bad + 1;
        stall_prev <= valid_a && !tx_ready_a && !reset;
        byte_prev  <= byte_a;
    end

    always @(posedge clock) begin
        if (valid_b) begin q_b.push_back(byte_b); t_b.push_back(cyc); end
        if (valid_c) begin q_c.push_back(byte_c); t_c.push_back(cyc); end
        if (valid_d) begin q_d.push_back(byte_d); t_d.push_back(cyc); end
        if (done_b) dn_b <= dn_b + 1;
        if (done_c) dn_c <= dn_c + 1;
        if (done_d) dn_d <= dn_d + 1;
        if (busy_d && seen3_d && addr_d != 2'd3) wrap_d <= wrap_d + 1;
        if (busy_d && addr_d == 2'd3) seen3_d <= 1'b1;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    bit throttle = 1'b0;
    int phase = 0;

    task automatic tick();
        @(negedge clock);
        if (throttle) begin
            tx_ready_a = (phase == 0);
            phase = (phase + 1) % 3;
        end
    endtask

    task automatic pulse_start(input int which);
        case (which)
            0: start_a = 1'b1;
            1: start_b = 1'b1;
            2: start_c = 1'b1;
            default: start_d = 1'b1;
        endcase
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
        start_d = 1'b0;
    endtask

    task automatic wait_done(input int which, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 600 && !seen; i++) begin
            tick();
            case (which)
                0: seen = done_a;
                1: seen = done_b;
                2: seen = done_c;
                default: seen = done_d;
            endcase
        end
        check({tag, " done seen"}, 32'(seen), 32'd1);
    endtask

    task automatic frame_check(input string tag, input logic [7:0] got[$],
                               input logic [7:0] exp[$]);
        check({tag, " length"}, got.size(), exp.size());
        foreach (exp[i]) begin
            check($sformatf("%s byte%0d", tag, i),
                  (i < got.size()) ? {24'h0, got[i]} : 32'hdead, {24'h0, exp[i]});
        end
    endtask

    logic [7:0] exp9[$]  = '{8'hA5, 8'h5A, 8'h00, 8'hFF, 8'h01, 8'hFE, 8'h02, 8'hFD, 8'hFF};
    logic [7:0] exp11[$] = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h11, 8'h11, 8'h22, 8'h22,
                             8'h33, 8'h33, 8'h00};

    initial begin
        int         b0, d0, ss0, sb0;
        bit         found;
        logic [7:0] got[$];

        reset      = 1'b1;
        start_a    = 1'b0;
        start_b    = 1'b0;
        start_c    = 1'b0;
        start_d    = 1'b0;
        tx_ready_a = 1'b1;
        ready_one  = 1'b1;
        repeat (3) tick();
        check("reset ADDRESS", 32'(addr_a), 32'd0);
        check("reset TX_BYTE", 32'(byte_a), 32'd0);
        check("reset TX_VALID", 32'(valid_a), 32'd0);
        check("reset BUSY", 32'(busy_a), 32'd0);
        check("reset DONE", 32'(done_a), 32'd0);
        reset = 1'b0;
        tick();

        // Basic frame, TX_READY held high
        b0 = q_a.size();
        d0 = dn_a;
        pulse_start(0);
        check("t1 BUSY after START", 32'(busy_a), 32'd1);
        wait_done(0, "t1");
        check("t1 ADDRESS at DONE", 32'(addr_a), 32'd2);
        repeat (3) tick();
        got = q_a[b0:$];
        frame_check("t1", got, exp9);
        check("t1 DONE count", dn_a - d0, 32'd1);
        check("t1 DONE timing", dc_a - t_a[b0+8], 32'd1);
        check("t1 sample gap", t_a[b0+4] - t_a[b0+3], 32'd4);
        check("t1 BUSY over frame", busy_bad, 32'd0);
        check("t1 BUSY after", 32'(busy_a), 32'd0);

        // Back-pressure: ready one cycle in three
        b0  = q_a.size();
        d0  = dn_a;
        ss0 = stall_seen;
        sb0 = stall_bad;
        throttle = 1'b1;
        phase    = 0;
        pulse_start(0);
        wait_done(0, "t2");
        throttle   = 1'b0;
        tx_ready_a = 1'b1;
        repeat (3) tick();
        got = q_a[b0:$];
        frame_check("t2", got, exp9);
        check("t2 DONE count", dn_a - d0, 32'd1);
        check("t2 stalls occurred", 32'(stall_seen > ss0), 32'd1);
        check("t2 byte stable in stall", stall_bad - sb0, 32'd0);

        // Reset while sample byte 01 is pending
        b0 = q_a.size();
        pulse_start(0);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            found = (q_a.size() - b0 == 4) && valid_a;
        end
        check("t3 pending byte", 32'(byte_a), 32'h01);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t3 TX_VALID", 32'(valid_a), 32'd0);
        check("t3 ADDRESS", 32'(addr_a), 32'd0);
        check("t3 BUSY", 32'(busy_a), 32'd0);
        check("t3 DONE", 32'(done_a), 32'd0);
        repeat (10) tick();
        check("t3 no resume", q_a.size() - b0, 32'd4);
        b0 = q_a.size();
        pulse_start(0);
        wait_done(0, "t3 restart");
        repeat (3) tick();
        got = q_a[b0:$];
        frame_check("t3 restart", got, exp9);

        // START re-pulsed during HDR1 and SEND must be ignored
        b0 = q_a.size();
        d0 = dn_a;
        pulse_start(0);
        tick();
        check("t4 in HDR1", 32'(byte_a), 32'h5A);
        pulse_start(0);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            found = (q_a.size() - b0 == 2) && valid_a;
        end
        check("t4 in SEND", 32'(byte_a), 32'h00);
        pulse_start(0);
        wait_done(0, "t4");
        repeat (20) tick();
        got = q_a[b0:$];
        frame_check("t4", got, exp9);
        check("t4 DONE count", dn_a - d0, 32'd1);
        check("t4 idle after", 32'(valid_a), 32'd0);

        // RESET and START on the same edge
        reset   = 1'b1;
        start_a = 1'b1;
        tick();
        reset   = 1'b0;
        start_a = 1'b0;
        check("t5 BUSY", 32'(busy_a), 32'd0);
        tick();
        check("t5 TX_VALID", 32'(valid_a), 32'd0);

        // Read latency 1 and 3
        pulse_start(1);
        wait_done(1, "rl1");
        repeat (3) tick();
        frame_check("rl1", q_b, exp9);
        check("rl1 sample gap", t_b[4] - t_b[3], 32'd3);
        check("rl1 DONE count", dn_b, 32'd1);
        pulse_start(2);
        wait_done(2, "rl3");
        repeat (3) tick();
        frame_check("rl3", q_c, exp9);
        check("rl3 sample gap", t_c[4] - t_c[3], 32'd5);
        check("rl3 DONE count", dn_c, 32'd1);

        // Full 2-bit address space
        pulse_start(3);
        wait_done(3, "full");
        check("full ADDRESS at DONE", 32'(addr_d), 32'd3);
        repeat (3) tick();
        frame_check("full", q_d, exp11);
        check("full no wrap", wrap_d, 32'd0);
        check("full DONE count", dn_d, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
